// File: rtl/upower_pkg.sv
// Shared definitions for the store unit: store opcodes, FSM state type and
// the opcode-to-byte-count decode.
package upower_pkg;

   localparam logic [5:0] OP_STB = 6'd38;
   localparam logic [5:0] OP_STH = 6'd44;
   localparam logic [5:0] OP_STW = 6'd36;
   localparam logic [5:0] OP_STD = 6'd62;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of bytes written by a store opcode; 0 marks an unsupported opcode.
   function automatic logic [3:0] byte_count(input logic [5:0] op);
      case (op)
         OP_STB:  byte_count = 4'd1;
         OP_STH:  byte_count = 4'd2;
         OP_STW:  byte_count = 4'd4;
         OP_STD:  byte_count = 4'd8;
         default: byte_count = 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/store_byte_sel.sv
// Big-endian byte picker: byte k of an N-byte store is the k-th most
// significant byte of the low N bytes of the store data.
module store_byte_sel (
   input  logic [63:0] data,
   input  logic [3:0]  nbytes,
   input  logic [2:0]  idx,
   output logic [7:0]  wdata
);

   logic [3:0] pos;

   // Byte position counted from the LSB is N-1-k; shift it down to bits [7:0].
   always_comb begin
      pos   = nbytes - 4'd1 - {1'b0, idx};
      wdata = 8'(data >> {pos, 3'b000});
   end

endmodule

// File: rtl/store_unit.sv
// Byte-serial store unit: computes the effective address of a stb/sth/stw/std,
// then writes the store data to memory one byte per acknowledged cycle,
// most significant byte first.
module store_unit
   import upower_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [5:0]  opcode,
   input  logic [4:0]  ra,
   input  logic [63:0] ReadData1,
   input  logic [63:0] ReadData2,
   input  logic [15:0] disp,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic        mem_ack,
   output logic        busy,
   output logic        done,
   output logic        error
);

   state_t      state, state_nx;
   logic [63:0] data_q;
   logic [63:0] ea_q;
   logic [3:0]  nbytes_q;
   logic [2:0]  cnt;
   logic        err_q;

   logic [3:0]  nbytes_in;
   logic [63:0] base;
   logic [63:0] ext;
   logic [63:0] ea_in;
   logic        illegal;
   logic        last;
   logic [7:0]  sel_byte;

   store_byte_sel u_sel (
      .data   (data_q),
      .nbytes (nbytes_q),
      .idx    (cnt),
      .wdata  (sel_byte)
   );

   // Request decode: byte count, effective address and legality of the inputs.
   always_comb begin
      nbytes_in = byte_count(opcode);
      base      = (ra == 5'd0) ? 64'd0 : ReadData2;
      if (opcode == OP_STD) ext = {{48{disp[15]}}, disp[15:2], 2'b00};
      else                  ext = {{48{disp[15]}}, disp};
      ea_in     = base + ext;
      illegal   = (nbytes_in == 4'd0) || ((opcode == OP_STD) && (disp[1:0] != 2'b00));
      last      = ({1'b0, cnt} == (nbytes_q - 4'd1));
   end

   // Next-state and output decode; address/data are forced to 0 outside XFER.
   always_comb begin
      state_nx = state;
      mem_req  = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      error    = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nx = illegal ? DONE : XFER;
         end
         XFER: begin
            mem_req = 1'b1;
            if (mem_ack && last) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            error    = err_q;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      mem_addr  = mem_req ? (ea_q + {61'd0, cnt}) : 64'd0;
      mem_wdata = mem_req ? sel_byte : 8'd0;
   end

   // Control state: FSM register, byte counter and latched error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 3'd0;
         err_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            cnt   <= 3'd0;
            err_q <= illegal;
         end else if (state == XFER && mem_ack) begin
            cnt <= cnt + 3'd1;
         end
      end
   end

   // Request capture: inputs are only sampled on an accepted start.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         data_q   <= ReadData1;
         ea_q     <= ea_in;
         nbytes_q <= nbytes_in;
      end
   end

endmodule
